// File: rtl/ps2_key_tracker_pkg.sv
// Shared types and constants for the PS/2 key tracker: key codes, prefix bytes,
// frame receiver states and the default 13-key map.
package ps2_key_tracker_pkg;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_code_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1e;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2e;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3d;
    localparam logic [7:0] KEY_MINUS = 8'h4e;
    localparam logic [7:0] KEY_PLUS  = 8'h55;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6b;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [7:0] PFX_EXT   = 8'he0;
    localparam logic [7:0] PFX_BRK   = 8'hf0;
    localparam logic [7:0] PFX_PAUSE = 8'he1;

    localparam int DEFAULT_NUM_KEYS = 13;

    // Entry i occupies bits [i*9 +: 9]; listed here from key 12 down to key 0.
    localparam logic [DEFAULT_NUM_KEYS*9-1:0] DEFAULT_KEY_MAP = {
        1'b1, KEY_RIGHT,
        1'b1, KEY_LEFT,
        1'b1, KEY_DOWN,
        1'b1, KEY_UP,
        1'b0, KEY_PLUS,
        1'b0, KEY_MINUS,
        1'b0, KEY_7,
        1'b0, KEY_6,
        1'b0, KEY_5,
        1'b0, KEY_4,
        1'b0, KEY_3,
        1'b0, KEY_2,
        1'b0, KEY_1
    };

endpackage

// File: rtl/ps2_key_tracker_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, ps2_clk fall detect, 11-bit frame FSM
// and inter-fall timeout. Result strobes are combinational in the cycle the
// stop-bit fall is seen; the parent registers them.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data=0 on a fall)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | sampling the odd-parity bit
// RX_STOP   | sampling the stop bit, then report and return to idle
module ps2_frame_rx
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    rx_state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt;
    logic            parity_acc;
    logic [TO_W-1:0] to_cnt;
    logic            fall, din, timeout;

    assign fall    = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign din     = data_sync[SYNC_STAGES-1];
    assign timeout = (state != RX_IDLE) && (to_cnt == '0);
    assign rx_byte = shift_q;

    // Pin synchronisers; reset to the idle-high line level so no false fall appears.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= RX_IDLE;
        else            state <= state_nxt;
    end

    // Next state and result strobes; a fall always wins over a coincident timeout.
    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        if (fall) begin
            unique case (state)
                RX_IDLE:   if (!din) state_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (!din)            frame_err  = 1'b1;
                    else if (!parity_acc) parity_err = 1'b1;
                    else                 byte_valid = 1'b1;
                end
                default:   state_nxt = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = RX_IDLE;
            frame_err = 1'b1;
        end
    end

    // Shift register, bit counter and running parity (odd parity => accumulator ends at 1).
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    bit_cnt    <= '0;
                    parity_acc <= 1'b0;
                end
                RX_DATA: begin
                    shift_q    <= {din, shift_q[7:1]};
                    bit_cnt    <= bit_cnt + 3'd1;
                    parity_acc <= parity_acc ^ din;
                end
                RX_PARITY: parity_acc <= parity_acc ^ din;
                default: ;
            endcase
        end
    end

    // Timeout down-counter, reloaded on every fall and while idle.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                     to_cnt <= '0;
        else if (fall || state == RX_IDLE)  to_cnt <= TO_LOAD;
        else if (to_cnt != '0)              to_cnt <= to_cnt - 1'b1;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: decodes E0/F0 prefixes from received bytes and keeps
// held (key_down) and sticky (key_latched) state for each mapped key.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                      NUM_KEYS    = DEFAULT_NUM_KEYS,
    parameter logic [NUM_KEYS*9-1:0]   KEY_MAP     = DEFAULT_KEY_MAP,
    parameter int                      TIMEOUT_CYC = 100_000,
    parameter int                      SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                latch_clr,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_latched,
    output logic                evt_valid,
    output logic [7:0]          evt_code,
    output logic                evt_ext,
    output logic                evt_break,
    output logic                evt_hit,
    output logic                parity_err,
    output logic                frame_err
);

    logic          byte_valid, rx_perr, rx_ferr;
    logic [7:0]    rx_byte;
    logic          ext_q, brk_q;
    logic          is_prefix, code_valid;
    key_code_t     cur_key;
    logic [NUM_KEYS-1:0] hit, make_hit, brk_hit;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .parity_err (rx_perr),
        .frame_err  (rx_ferr)
    );

    assign is_prefix  = (rx_byte == PFX_EXT) || (rx_byte == PFX_BRK) || (rx_byte == PFX_PAUSE);
    assign code_valid = byte_valid && !is_prefix;
    assign cur_key    = '{ext: ext_q, code: rx_byte};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        assign hit[i] = code_valid && (cur_key == key_code_t'(KEY_MAP[i*9 +: 9]));
    end

    assign make_hit = brk_q ? '0  : hit;
    assign brk_hit  = brk_q ? hit : '0;

    // Prefix flags: set by E0/F0, cleared by any final byte, E1 or receive error.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (rx_perr || rx_ferr) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PFX_EXT) begin
                ext_q <= 1'b1;
            end else if (rx_byte == PFX_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // Event strobes and held event fields.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_hit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            evt_valid  <= code_valid;
            parity_err <= rx_perr;
            frame_err  <= rx_ferr;
            if (code_valid) begin
                evt_code  <= rx_byte;
                evt_ext   <= ext_q;
                evt_break <= brk_q;
                evt_hit   <= |hit;
            end
        end
    end

    // Key state; a make in the same cycle as latch_clr keeps its latched bit.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_down    <= '0;
            key_latched <= '0;
        end else begin
            key_down    <= (key_down & ~brk_hit) | make_hit;
            key_latched <= (latch_clr ? '0 : key_latched) | make_hit;
        end
    end

endmodule
